// File: rtl/feed_scheduler.sv
// feed_scheduler: time-slot and manual pet-feeder motor sequencer.
// Each slot fires once when ctime enters its programmed BCD second. A manual
// request queues a single-portion job. Pending jobs run one at a time, lowest
// slot index first and manual last. Every portion runs OPEN, then DWELL, then
// CLOSE, with motor drives held during each phase.
//
// Ports:
//   Clk, Reset        clock, synchronous active-high reset
//   ctime             current time, BCD {h2,h1,m2,m1,s2,s1}
//   ld_en/ld_slot     one-cycle slot load strobe and target slot index
//   ld_time           BCD feed time for the loaded slot
//   ld_portions       portions per feed for the loaded slot (0 disables it)
//   manual            one-cycle single-portion feed request
//   PulseAngleRot     OPEN phase length in cycles (CLOSE adds CLOSE_EXTRA)
//   delay             DWELL phase length in cycles
//   ME, MT1, MT2      motor enable and terminal drives (registered)
//   busy              high while a job is active
//   done              one-cycle pulse at job completion
//   cur_src           source of the active or last job (slot index, 15 = manual)
module feed_scheduler #(
  parameter int unsigned SLOTS       = 4,
  parameter int unsigned CW          = 32,
  parameter int unsigned CLOSE_EXTRA = 700000
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [23:0]   ctime,
  input  logic          ld_en,
  input  logic [2:0]    ld_slot,
  input  logic [23:0]   ld_time,
  input  logic [3:0]    ld_portions,
  input  logic          manual,
  input  logic [CW-1:0] PulseAngleRot,
  input  logic [CW-1:0] delay,
  output logic          ME,
  output logic          MT1,
  output logic          MT2,
  output logic          busy,
  output logic          done,
  output logic [3:0]    cur_src
);

  localparam int unsigned TW = 24;
  localparam int unsigned PW = 4;
  localparam int unsigned IW = 3;
  localparam int unsigned SW = 4;
  localparam int unsigned LW = CW + 1;
  localparam logic [SW-1:0] SRC_MANUAL = SW'(15);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OPEN  = 2'd1,
    ST_DWELL = 2'd2,
    ST_CLOSE = 2'd3
  } state_t;

  state_t state, next_state;

  logic [TW-1:0]    slot_time [SLOTS];
  logic [PW-1:0]    slot_port [SLOTS];
  logic [SLOTS-1:0] armed, pending;
  logic             man_pend;

  logic [SLOTS-1:0] ld_hit, slot_match, eff_pend, grant_mask;
  logic [SW-1:0]    grant_src;
  logic [PW-1:0]    grant_port;
  logic             grant_man, grant_any, start;

  logic [LW-1:0]    cnt;
  logic [LW-1:0]    close_len;
  logic [PW-1:0]    rem;
  logic [CW-1:0]    pa_lat, dl_lat;
  logic             phase_end, last_portion;

  logic me_c, mt1_c, mt2_c, busy_c, done_c;

  // Per-slot load decode and time match
  always_comb begin
    ld_hit     = '0;
    slot_match = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      ld_hit[i]     = ld_en && (ld_slot == IW'(i));
      slot_match[i] = (slot_port[i] != '0) && (slot_time[i] == ctime);
    end
  end

  // A same-cycle load cancels that slot's pending request before it can be granted
  assign eff_pend = pending & ~ld_hit;

  // Lowest-index pending slot wins; manual only when no slot is pending
  always_comb begin
    logic found;
    found      = 1'b0;
    grant_mask = '0;
    grant_src  = SRC_MANUAL;
    grant_port = PW'(1);
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (eff_pend[i] && !found) begin
        found         = 1'b1;
        grant_mask[i] = 1'b1;
        grant_src     = SW'(i);
        grant_port    = slot_port[i];
      end
    end
    grant_man = !found && man_pend;
    grant_any = found || man_pend;
  end

  assign start        = (state == ST_IDLE) && grant_any;
  assign phase_end    = (cnt < LW'(2));
  assign last_portion = (rem == PW'(1));
  assign close_len    = LW'(pa_lat) + LW'(CLOSE_EXTRA);

  // Slot table, arming and pending requests
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < SLOTS; i++) begin
        slot_time[i] <= '0;
        slot_port[i] <= '0;
      end
      armed    <= '0;
      pending  <= '0;
      man_pend <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < SLOTS; i++) begin
        if (ld_hit[i]) begin
          slot_time[i] <= ld_time;
          slot_port[i] <= ld_portions;
          pending[i]   <= 1'b0;
          armed[i]     <= 1'b0;
        end else begin
          if (start && grant_mask[i]) pending[i] <= 1'b0;
          // Fire once on entry to the matching second; re-arm once it no longer matches
          if (slot_match[i]) begin
            if (armed[i]) begin
              pending[i] <= 1'b1;
              armed[i]   <= 1'b0;
            end
          end else begin
            armed[i] <= 1'b1;
          end
        end
      end
      if (manual) man_pend <= 1'b1;
      else if (start && grant_man) man_pend <= 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge Clk) begin
    if (Reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // FSM next state
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (grant_any) next_state = ST_OPEN;
      ST_OPEN:  if (phase_end) next_state = ST_DWELL;
      ST_DWELL: if (phase_end) next_state = ST_CLOSE;
      ST_CLOSE: if (phase_end) next_state = last_portion ? ST_IDLE : ST_OPEN;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Output decode from the state being entered, so drives line up with the state
  always_comb begin
    me_c   = 1'b0;
    mt1_c  = 1'b0;
    mt2_c  = 1'b0;
    busy_c = (next_state != ST_IDLE);
    done_c = (state == ST_CLOSE) && phase_end && last_portion;
    case (next_state)
      ST_OPEN:  begin me_c = 1'b1; mt1_c = 1'b1; end
      ST_CLOSE: begin me_c = 1'b1; mt2_c = 1'b1; end
      default:  ;
    endcase
  end

  // Registered outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ME   <= 1'b0;
      MT1  <= 1'b0;
      MT2  <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      ME   <= me_c;
      MT1  <= mt1_c;
      MT2  <= mt2_c;
      busy <= busy_c;
      done <= done_c;
    end
  end

  // Job datapath: phase counter, remaining portions, lengths latched at job start
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt     <= '0;
      rem     <= '0;
      pa_lat  <= '0;
      dl_lat  <= '0;
      cur_src <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            cnt     <= LW'(PulseAngleRot);
            pa_lat  <= PulseAngleRot;
            dl_lat  <= delay;
            rem     <= grant_port;
            cur_src <= grant_src;
          end
        end
        ST_OPEN:  cnt <= phase_end ? LW'(dl_lat) : cnt - LW'(1);
        ST_DWELL: cnt <= phase_end ? close_len : cnt - LW'(1);
        ST_CLOSE: begin
          if (phase_end) begin
            rem <= rem - PW'(1);
            cnt <= LW'(pa_lat);
          end else begin
            cnt <= cnt - LW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_feed_scheduler.sv
// Directed bench for feed_scheduler: a per-cycle vector table for a
// zero-length manual feed, then hand-written multi-cycle scenarios.
module tb_feed_scheduler;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [23:0] ctime = '0;
  logic        ld_en = 1'b0;
  logic [2:0]  ld_slot = '0;
  logic [23:0] ld_time = '0;
  logic [3:0]  ld_portions = '0;
  logic        manual = 1'b0;
  logic [31:0] PulseAngleRot = '0;
  logic [31:0] delay = '0;
  logic        ME, MT1, MT2, busy, done;
  logic [3:0]  cur_src;

  feed_scheduler #(.SLOTS(4), .CW(32), .CLOSE_EXTRA(2)) dut (
    .Clk(Clk), .Reset(Reset), .ctime(ctime), .ld_en(ld_en), .ld_slot(ld_slot),
    .ld_time(ld_time), .ld_portions(ld_portions), .manual(manual),
    .PulseAngleRot(PulseAngleRot), .delay(delay),
    .ME(ME), .MT1(MT1), .MT2(MT2), .busy(busy), .done(done), .cur_src(cur_src)
  );

  always #5 Clk = ~Clk;

  // exp = {ME, MT1, MT2, busy, done, cur_src}
  typedef struct {
    logic       rst;
    logic       man;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs [8];

  int n_pass = 0;
  int n_total = 0;
  int c_busy, c_open, c_dwell, c_close, c_done;
  logic [3:0] src_log [4];

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Advance n cycles and tally what the outputs did
  task automatic run(input int n);
    c_busy = 0; c_open = 0; c_dwell = 0; c_close = 0; c_done = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (busy) c_busy++;
      if (ME && MT1 && !MT2) c_open++;
      if (busy && !ME && !MT1 && !MT2) c_dwell++;
      if (ME && !MT1 && MT2) c_close++;
      if (done) begin
        if (c_done < 4) src_log[c_done] = cur_src;
        c_done++;
      end
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1; manual = 1'b0; ld_en = 1'b0; ctime = '0;
    step();
    Reset = 1'b0;
  endtask

  task automatic load(input logic [2:0] s, input logic [23:0] t, input logic [3:0] p);
    ld_en = 1'b1; ld_slot = s; ld_time = t; ld_portions = p;
    step();
    ld_en = 1'b0;
  endtask

  initial begin
    // Manual feed with zero-length phases: OPEN 1, DWELL 1, CLOSE 2
    vecs[0] = '{1'b1, 1'b0, {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0}};
    vecs[1] = '{1'b0, 1'b1, {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0}};
    vecs[2] = '{1'b0, 1'b0, {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'hF}};
    vecs[3] = '{1'b0, 1'b0, {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF}};
    vecs[4] = '{1'b0, 1'b0, {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'hF}};
    vecs[5] = '{1'b0, 1'b0, {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'hF}};
    vecs[6] = '{1'b0, 1'b0, {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF}};
    vecs[7] = '{1'b0, 1'b0, {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF}};

    PulseAngleRot = 32'd0;
    delay = 32'd0;
    for (int i = 0; i < 8; i++) begin
      Reset = vecs[i].rst;
      manual = vecs[i].man;
      step();
      check($sformatf("vec%0d", i), {ME, MT1, MT2, busy, done, cur_src}, vecs[i].exp);
    end
    manual = 1'b0;

    // Two-portion slot feed, 13 cycles per portion, no refire while ctime holds
    PulseAngleRot = 32'd4;
    delay = 32'd3;
    do_reset();
    load(3'd0, 24'h083000, 4'd2);
    step();
    ctime = 24'h083000;
    step();
    check("a_pend_not_busy", busy, 1'b0);
    step();
    check("a_open_latency", {ME, MT1, MT2, busy}, 4'b1101);
    check("a_src", cur_src, 4'd0);
    PulseAngleRot = 32'd20;
    delay = 32'd20;
    run(49);
    check("a_busy_cycles", c_busy, 25);
    check("a_open_cycles", c_open, 7);
    check("a_dwell_cycles", c_dwell, 6);
    check("a_close_cycles", c_close, 12);
    check("a_done_pulses", c_done, 1);
    PulseAngleRot = 32'd4;
    delay = 32'd3;

    // Two slots at the same time: lower index first, then the other
    do_reset();
    load(3'd1, 24'h120000, 4'd1);
    load(3'd2, 24'h120000, 4'd1);
    step();
    ctime = 24'h120000;
    run(40);
    check("b_done_pulses", c_done, 2);
    check("b_busy_cycles", c_busy, 26);
    check("b_first_src", src_log[0], 4'd1);
    check("b_second_src", src_log[1], 4'd2);

    // Two manual pulses during a slot job yield one manual job afterwards
    do_reset();
    load(3'd3, 24'h070000, 4'd1);
    step();
    ctime = 24'h070000;
    step();
    step();
    manual = 1'b1;
    step();
    manual = 1'b0;
    step();
    step();
    manual = 1'b1;
    step();
    manual = 1'b0;
    run(40);
    check("c_done_pulses", c_done, 2);
    check("c_busy_cycles", c_busy, 21);
    check("c_first_src", src_log[0], 4'd3);
    check("c_manual_src", src_log[1], 4'hF);

    // Reset in DWELL aborts the job and clears the slot
    do_reset();
    load(3'd2, 24'h090000, 4'd1);
    step();
    ctime = 24'h090000;
    step();
    for (int i = 0; i < 5; i++) step();
    check("d_in_dwell", {ME, MT1, MT2, busy, cur_src}, {4'b0001, 4'd2});
    Reset = 1'b1;
    step();
    check("d_reset_outputs", {ME, MT1, MT2, busy, done, cur_src}, 9'd0);
    Reset = 1'b0;
    run(5);
    check("d_no_done_after_reset", c_done, 0);
    ctime = 24'h000000;
    step();
    step();
    ctime = 24'h090000;
    run(20);
    check("d_no_refire", c_busy, 0);

    // Disabling a pending slot cancels it; loads to out-of-range slots are ignored
    do_reset();
    load(3'd5, 24'h100000, 4'd1);
    load(3'd0, 24'h100000, 4'd3);
    step();
    ctime = 24'h100000;
    step();
    check("e_pend_not_busy", busy, 1'b0);
    load(3'd0, 24'h100000, 4'd0);
    check("e_cancel_same_edge", {ME, busy}, 2'b00);
    run(30);
    check("e_no_activity", c_busy + c_open + c_close, 0);
    check("e_no_done", c_done, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/feed_scheduler.md
FEED_SCHEDULER -- requirements
Module: feed_scheduler

Interface
REQ-001 Parameter SLOTS, default 4: number of independent feeding-time slots (1..8).
REQ-002 Parameter CW, default 32: width of the phase-length inputs and the internal phase counter.
REQ-003 Parameter CLOSE_EXTRA, default 700000: extra cycles added to the close phase.
REQ-004 Port Clk, input, 1: single clock for all logic.
REQ-005 Port Reset, input, 1: synchronous, active-high reset.
REQ-006 Port ctime, input, 24: current time as six BCD digits {h2,h1,m2,m1,s2,s1}.
REQ-007 Port ld_en, input, 1: one-cycle slot-load strobe.
REQ-008 Port ld_slot, input, 3: index of the slot to load; values >= SLOTS are ignored.
REQ-009 Port ld_time, input, 24: BCD feed time for the loaded slot.
REQ-010 Port ld_portions, input, 4: portions per feed for the loaded slot; 0 disables the slot.
REQ-011 Port manual, input, 1: one-cycle request for a single-portion feed.
REQ-012 Port PulseAngleRot, input, CW: open-phase length in cycles.
REQ-013 Port delay, input, CW: dwell-phase length in cycles.
REQ-014 Port ME, MT1, MT2, output, 1 each: motor enable and motor terminal drives.
REQ-015 Port busy, input/output direction output, 1: high whenever state != IDLE.
REQ-016 Port done, output, 1: one-cycle pulse when a feed job completes.
REQ-017 Port cur_src, output, 4: source of the active job; 0..SLOTS-1 = slot, 15 = manual.

Function
REQ-018 Each slot SHALL hold time[23:0], portions[3:0], armed, and pending.
REQ-019 The slot "match" condition SHALL be portions!=0 AND time==ctime.
REQ-020 If a slot matches and is armed, the block SHALL set pending and clear armed on that edge.
REQ-021 If a slot does not match, the block SHALL set armed, so each match fires exactly once per entry into the matching second.
REQ-022 A ld_en for slot i SHALL write time and portions, and clear pending[i] and armed[i]; it takes priority over fire logic for slot i in the same cycle.
REQ-023 A manual pulse SHALL set the manual pending bit; further pulses while that bit is pending are absorbed.
REQ-024 FSM states SHALL be IDLE, OPEN, DWELL, CLOSE.
REQ-025 In IDLE with any pending bit set, on the next edge the FSM SHALL:
- select the lowest-index pending slot, with manual lowest priority;
- clear that pending bit;
- latch the portion count (manual = 1), PulseAngleRot and delay;
- set cur_src;
- enter OPEN.
REQ-026 Each phase of latched length L SHALL last max(L,1) cycles.
REQ-027 The close length SHALL equal PulseAngleRot + CLOSE_EXTRA, computed at CW+1 bits without overflow.
REQ-028 Motor outputs SHALL be registered as follows:
- OPEN: ME=1, MT1=1, MT2=0;
- CLOSE: ME=1, MT1=0, MT2=1;
- IDLE and DWELL: all 0.
REQ-029 The transitions SHALL be OPEN -> DWELL -> CLOSE.
REQ-030 At the end of CLOSE, the block SHALL decrement the remaining portions; if the result is nonzero it SHALL go to OPEN, otherwise to IDLE with done=1 for one cycle.
REQ-031 Pending bits and slot loads arriving while busy SHALL be retained and serviced after the current job; the active job is unaffected.
REQ-032 Latency: with ctime matching before edge k, pending SHALL be set at edge k, and OPEN outputs SHALL appear after edge k+1 when IDLE.
REQ-033 Changes to PulseAngleRot or delay during a job SHALL have no effect until the next job starts.

Reset
REQ-034 While Reset=1 at a clock edge, the block SHALL set:
- state IDLE;
- ME, MT1, MT2, busy, done = 0;
- cur_src = 0;
- all slot times and portions = 0;
- all armed and pending bits = 0;
- the counter = 0.
REQ-035 Reset asserted mid-job SHALL abort the job and drop all outputs to 0 at that edge, with no done pulse.

Verification (PulseAngleRot=4, delay=3, CLOSE_EXTRA=2)
REQ-036 Scenario: load slot0 = 08:30:00 with 2 portions, then step ctime to 083000 and hold it. Required response:
- two cycles of OPEN(4 cycles) / DWELL(3) / CLOSE(6), 26 cycles total;
- one done pulse;
- no refire while ctime stays 083000.
REQ-037 Scenario: slots 1 and 2 both = 12:00:00 with 1 portion each. Required response: slot1 is serviced first, then slot2 immediately after, with cur_src 1 then 2 and two done pulses.
REQ-038 Scenario: manual pulse during a slot job, plus a second manual pulse. Required response: exactly one extra 1-portion job with cur_src=15, serviced after the slot job.
REQ-039 Scenario: PulseAngleRot=0, delay=0. Required response: OPEN 1 cycle, DWELL 1 cycle, CLOSE 2 cycles.
REQ-040 Scenario: Reset asserted in DWELL. Required response: outputs are 0 next cycle; the slot is disabled and does not refire at its old time.
REQ-041 Scenario: ld_en to slot0 with portions=0 while slot0 is pending. Required response: the pending request is cancelled and no motor activity occurs.
